soc_system_cmd_fifo_out: RTL

//  HPS-to-fabric command path: Avalon-MM slave that the HPS writes 32-bit command words into.

---
 rtl/soc_system_cmd_fifo_pkg.sv | 36 +++
 rtl/soc_system_cmd_fifo_mem.sv | 73 +++++++
 rtl/soc_system_cmd_fifo_out.sv | 137 +++++++++++++
 3 files changed

// File: rtl/soc_system_cmd_fifo_pkg.sv
// rtl/soc_system_cmd_fifo_pkg.sv - register map, field positions and status packing for the HPS command FIFO
package soc_system_cmd_fifo_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] REG_PUSH      = 2'd0;
    localparam logic [1:0] REG_STATUS    = 2'd1;
    localparam logic [1:0] REG_CTRL      = 2'd2;
    localparam logic [1:0] REG_POP_COUNT = 2'd3;

    localparam int STAT_OVERFLOW_BIT = 31;
    localparam int STAT_FULL_BIT     = 30;
    localparam int STAT_EMPTY_BIT    = 29;
    localparam int STAT_OVF_CLR_BIT  = 31;
    // level lives in the low bits and must never reach the flag bits
    localparam int STAT_LEVEL_MAX_W  = 29;

    localparam int CTRL_FLUSH_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    function automatic logic [DATA_W-1:0] pack_status(
        input logic                        overflow,
        input logic                        full,
        input logic                        empty,
        input logic [STAT_LEVEL_MAX_W-1:0] level_ext
    );
        logic [DATA_W-1:0] w;
        w = '0;
        w[STAT_LEVEL_MAX_W-1:0] = level_ext;
        w[STAT_OVERFLOW_BIT]    = overflow;
        w[STAT_FULL_BIT]        = full;
        w[STAT_EMPTY_BIT]       = empty;
        return w;
    endfunction

endpackage

// File: rtl/soc_system_cmd_fifo_mem.sv
// rtl/soc_system_cmd_fifo_mem.sv - first-word-fall-through storage with pointers, level and full/empty
module soc_system_cmd_fifo_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  wr_en;
    logic                  rd_en;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign rd_en = pop & ~empty;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign wr_en = push & ~flush & (~full | rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (DEPTH_LOG2 + 1)'(wr_en) - (DEPTH_LOG2 + 1)'(rd_en);
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/soc_system_cmd_fifo_out.sv
// rtl/soc_system_cmd_fifo_out.sv - Avalon-MM slave feeding HPS command words into a fabric stream FIFO
// Define SOC_CMD_FIFO_IRQ_EN for the low-watermark irq output and control bit1.
module soc_system_cmd_fifo_out
    import soc_system_cmd_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
`ifdef SOC_CMD_FIFO_IRQ_EN
    ,
    parameter int LOW_WM     = 2
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef SOC_CMD_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic                        wr_strobe;
    logic                        push_req;
    logic                        flush;
    logic                        ovf_clr;
    logic                        pop;
    logic [DEPTH_LOG2:0]         level;
    logic                        full;
    logic                        empty;
    logic [STAT_LEVEL_MAX_W-1:0] level_ext;
    logic [DATA_W-1:0]           ctrl_word;

    logic                        overflow_q, overflow_d;
    logic [DATA_W-1:0]           pop_count_q, pop_count_d;
    logic [DATA_W-1:0]           readdata_q, readdata_d;

    assign wr_strobe = chipselect & ~write_n;
    assign push_req  = wr_strobe & (address == REG_PUSH);
    assign flush     = wr_strobe & (address == REG_CTRL) & writedata[CTRL_FLUSH_BIT];
    assign ovf_clr   = wr_strobe & (address == REG_STATUS) & writedata[STAT_OVF_CLR_BIT];

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign readdata  = readdata_q;

    soc_system_cmd_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset_n),
        .push    (push_req),
        .pop     (pop),
        .flush   (flush),
        .wr_data (writedata),
        .rd_data (out_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

`ifdef SOC_CMD_FIFO_IRQ_EN
    localparam logic [DEPTH_LOG2:0] LOW_WM_LEVEL = (DEPTH_LOG2 + 1)'(LOW_WM);

    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;

    assign irq = irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_strobe && (address == REG_CTRL)) begin
            irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        end
        irq_d = irq_en_q & (level <= LOW_WM_LEVEL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    always_comb begin
        overflow_d = overflow_q;
        // a push into a full FIFO is dropped unless the same cycle pops or flushes
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end else if (push_req && !flush && full && !pop) begin
            overflow_d = 1'b1;
        end

        pop_count_d = pop_count_q + DATA_W'(pop);

        level_ext = '0;
        level_ext[DEPTH_LOG2:0] = level;

        ctrl_word = '0;
`ifdef SOC_CMD_FIFO_IRQ_EN
        ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
`else
        ctrl_word[CTRL_IRQ_EN_BIT] = 1'b0;
`endif

        case (address)
            REG_PUSH:      readdata_d = '0;
            REG_STATUS:    readdata_d = pack_status(overflow_q, full, empty, level_ext);
            REG_CTRL:      readdata_d = ctrl_word;
            REG_POP_COUNT: readdata_d = pop_count_q;
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            pop_count_q <= '0;
            readdata_q  <= '0;
        end else begin
            overflow_q  <= overflow_d;
            pop_count_q <= pop_count_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule
